// File: rtl/conv_encoder_axis.sv
// Streaming convolutional encoder, one info bit in / one coded symbol out per cycle.
// Define ENDEC_ZERO_TAIL_EN to append K-1 zero tail bits that return the trellis to state 0.
module conv_encoder_axis #(
    parameter int MAX_K    = 9,
    parameter int MAX_RATE = 3,
    parameter int KW       = $clog2(MAX_K + 1)
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_code_rate,
    input  logic [KW-1:0]             i_constr_len,
    input  logic [MAX_K*MAX_RATE-1:0] i_gen_poly_flat,
    input  logic                      s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic [MAX_RATE-1:0]       m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
`ifdef ENDEC_ZERO_TAIL_EN
        S_TAIL  = 2'd2,
`endif
        S_DRAIN = 2'd3
    } state_e;

    typedef logic [MAX_RATE-1:0][MAX_K-1:0] poly_t;

    // Lanes 0 and 1 are always used; lane 2 only at rate 1/3.
    function automatic logic lane_on(input int j, input logic rate);
        return (j < 2) || (rate && (j == 2));
    endfunction

    state_e                 state_q, state_d;
    poly_t                  poly_q, poly_d;
    logic [MAX_K-2:0]       sr_q, sr_d;
    logic [MAX_RATE-1:0]    mdata_q, mdata_d;
    logic                   mvalid_q, mvalid_d;
    logic                   mlast_q, mlast_d;
    logic                   done_q, done_d;
    logic                   cerr_q, cerr_d;
`ifdef ENDEC_ZERO_TAIL_EN
    logic [KW-1:0]          k_q, k_d;
    logic [KW-1:0]          cnt_q, cnt_d;
`endif

    logic                   free;
    logic                   load;
    logic                   in_bit;
    logic                   last_sym;
    logic                   bad;
    logic [MAX_K-1:0]       kmask;
    logic [MAX_K-1:0]       pj;
    logic [MAX_K-1:0]       win;
    poly_t                  newpoly;

    // The single-entry output register can take a new symbol when empty or draining.
    assign free      = !mvalid_q || m_tready;
    assign s_tready  = (state_q == S_RUN) && free;
    assign m_tdata   = mdata_q;
    assign m_tvalid  = mvalid_q;
    assign m_tlast   = mlast_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = done_q;
    assign o_cfg_err = cerr_q;

    // Next-state, config validation and symbol computation.
    always_comb begin
        state_d  = state_q;
        poly_d   = poly_q;
        sr_d     = sr_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        mlast_d  = mlast_q;
        done_d   = 1'b0;
        cerr_d   = 1'b0;
`ifdef ENDEC_ZERO_TAIL_EN
        k_d      = k_q;
        cnt_d    = cnt_q;
`endif
        load     = 1'b0;
        in_bit   = 1'b0;
        last_sym = 1'b0;
        bad      = 1'b0;
        kmask    = '0;
        pj       = '0;
        win      = '0;
        newpoly  = '0;

        // A consumed symbol empties the register unless refilled below.
        if (mvalid_q && m_tready) begin
            mvalid_d = 1'b0;
            mdata_d  = '0;
            mlast_d  = 1'b0;
        end

        for (int i = 0; i < MAX_K; i++) begin
            kmask[i] = (i < int'(i_constr_len));
        end
        if ((i_constr_len < KW'(3)) || (i_constr_len > KW'(MAX_K))) begin
            bad = 1'b1;
        end
        for (int j = 0; j < MAX_RATE; j++) begin
            pj = i_gen_poly_flat[j*MAX_K +: MAX_K] & kmask;
            if (lane_on(j, i_code_rate)) begin
                newpoly[j] = pj;
                if (pj == '0) begin
                    bad = 1'b1;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (bad) begin
                        cerr_d = 1'b1;
                    end else begin
                        poly_d  = newpoly;
                        sr_d    = '0;
                        state_d = S_RUN;
`ifdef ENDEC_ZERO_TAIL_EN
                        k_d     = i_constr_len;
`endif
                    end
                end
            end
            S_RUN: begin
                if (s_tvalid && free) begin
                    load   = 1'b1;
                    in_bit = s_tdata;
                    if (s_tlast) begin
`ifdef ENDEC_ZERO_TAIL_EN
                        cnt_d   = k_q - KW'(1);
                        state_d = S_TAIL;
`else
                        last_sym = 1'b1;
                        state_d  = S_DRAIN;
`endif
                    end
                end
            end
`ifdef ENDEC_ZERO_TAIL_EN
            S_TAIL: begin
                if (free) begin
                    load     = 1'b1;
                    in_bit   = 1'b0;
                    last_sym = (cnt_q == KW'(1));
                    cnt_d    = cnt_q - KW'(1);
                    if (cnt_q == KW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if (mvalid_q && m_tready && mlast_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Latched polys are already K-masked and zero on unused lanes.
        if (load) begin
            win = {sr_q, in_bit};
            for (int j = 0; j < MAX_RATE; j++) begin
                mdata_d[j] = ^(poly_q[j] & win);
            end
            mlast_d  = last_sym;
            mvalid_d = 1'b1;
            sr_d     = {sr_q[MAX_K-3:0], in_bit};
        end
    end

    // State and output registers; reset aborts any frame silently.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            poly_q   <= '0;
            sr_q     <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            done_q   <= 1'b0;
            cerr_q   <= 1'b0;
`ifdef ENDEC_ZERO_TAIL_EN
            k_q      <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            poly_q   <= poly_d;
            sr_q     <= sr_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            mlast_q  <= mlast_d;
            done_q   <= done_d;
            cerr_q   <= cerr_d;
`ifdef ENDEC_ZERO_TAIL_EN
            k_q      <= k_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_conv_encoder_axis.sv
// Scoreboard bench for conv_encoder_axis: a convolution-sum reference model
// fills an expected-symbol queue that a negedge monitor drains.
module tb_conv_encoder_axis;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_code_rate = 1'b0;
    logic [3:0]  i_constr_len = '0;
    logic [26:0] i_gen_poly_flat = '0;
    logic        s_tdata = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [2:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic        o_cfg_err;

    conv_encoder_axis #(.MAX_K(9), .MAX_RATE(3)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .i_start(i_start),
        .i_code_rate(i_code_rate), .i_constr_len(i_constr_len),
        .i_gen_poly_flat(i_gen_poly_flat),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .o_busy(o_busy),
        .o_done(o_done), .o_cfg_err(o_cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    int         total = 0;
    int         bad = 0;
    logic [3:0] expq[$];
    logic [3:0] logq[$];
    bit         frame_bits[$];
    int         done_cnt = 0;
    int         cerr_cnt = 0;
    int         frames = 0;
    int         cerr_exp = 0;
    int         rmode = 0;
    int         rcnt = 0;
    bit         prev_stall = 0;
    logic [3:0] prev_sym = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    function automatic logic [26:0] mkpf(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        return {c, b, a};
    endfunction

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random, else held low.
    always @(posedge sys_clk) begin
        #1;
        case (rmode)
            0: m_tready = 1'b1;
            1: m_tready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            2: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
        rcnt++;
    end

    // Monitor: pop and compare on every handshake, check AXI hold and backpressure.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (o_done) done_cnt++;
            if (o_cfg_err) cerr_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_sym", 32'({m_tlast, m_tdata}), 32'(prev_sym));
            end
            if (m_tvalid && !m_tready) begin
                chk("s_tready_when_full", 32'(s_tready), 32'd0);
            end
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    fail_now("unexpected_symbol");
                end else begin
                    chk("symbol", 32'({m_tlast, m_tdata}), 32'(expq.pop_front()));
                end
                logq.push_back({m_tlast, m_tdata});
            end
            prev_stall = m_tvalid && !m_tready;
            prev_sym   = {m_tlast, m_tdata};
        end
    end

    // Reference: out_j[t] = XOR over i<K of g_j[i] & u[t-i], u padded with zeros.
    task automatic push_model(input int k, input bit rate, input logic [26:0] pf);
        int n;
        int len;
        n   = frame_bits.size();
        len = n;
`ifdef ENDEC_ZERO_TAIL_EN
        len = n + k - 1;
`endif
        for (int t = 0; t < len; t++) begin
            logic [3:0] s;
            s = '0;
            for (int j = 0; j < 3; j++) begin
                bit par;
                par = 0;
                if (j < 2 || rate) begin
                    for (int i = 0; i < k; i++) begin
                        if (pf[j*9+i] && (t - i) >= 0 && (t - i) < n) begin
                            par = par ^ frame_bits[t-i];
                        end
                    end
                end
                s[j] = par;
            end
            s[3] = (t == len - 1);
            expq.push_back(s);
        end
    endtask

    task automatic start_cfg(input int k, input bit rate, input logic [26:0] pf);
        @(posedge sys_clk); #1;
        i_constr_len    = 4'(k);
        i_code_rate     = rate;
        i_gen_poly_flat = pf;
        i_start         = 1'b1;
        @(posedge sys_clk); #1;
        i_start         = 1'b0;
        i_constr_len    = 4'($urandom_range(0, 15));
        i_code_rate     = 1'($urandom_range(0, 1));
        i_gen_poly_flat = 27'($urandom);
    endtask

    task automatic send_bit(input bit b, input bit last);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = b;
        s_tlast  = last;
        forever begin
            @(negedge sys_clk);
            if (s_tready) break;
            n++;
            if (n > 2000) begin
                fail_now("accept_timeout");
                break;
            end
        end
        @(posedge sys_clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((o_busy || expq.size() != 0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) fail_now("frame_timeout");
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic run_frame(input int k, input bit rate, input logic [26:0] pf, input int gapmax);
        int g;
        push_model(k, rate, pf);
        start_cfg(k, rate, pf);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        for (int b = 0; b < frame_bits.size(); b++) begin
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int c = 0; c < g; c++) begin
                @(posedge sys_clk); #1;
            end
            send_bit(frame_bits[b], b == frame_bits.size() - 1);
        end
        frames++;
        wait_idle(3000);
        chk("done_count", 32'(done_cnt), 32'(frames));
        chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic cfg_err_try(input int k, input bit rate, input logic [26:0] pf);
        cerr_exp++;
        start_cfg(k, rate, pf);
        repeat (2) @(negedge sys_clk);
        chk("cfg_err_pulses", 32'(cerr_cnt), 32'(cerr_exp));
        chk("cfg_err_busy", 32'(o_busy), 32'd0);
        chk("cfg_err_s_tready", 32'(s_tready), 32'd0);
    endtask

    task automatic check_test1(input string nm);
        logic [3:0] e1[$];
`ifdef ENDEC_ZERO_TAIL_EN
        e1 = '{4'h3, 4'h1, 4'h0, 4'h2, 4'h2, 4'hb};
`else
        e1 = '{4'h3, 4'h1, 4'h0, 4'ha};
`endif
        chk({nm, "_len"}, 32'(logq.size()), 32'(e1.size()));
        for (int i = 0; i < e1.size() && i < logq.size(); i++) begin
            chk({nm, "_sym"}, 32'(logq[i]), 32'(e1[i]));
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({nm, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({nm, "_m_tlast"}, 32'(m_tlast), 32'd0);
        chk({nm, "_m_tdata"}, 32'(m_tdata), 32'd0);
        chk({nm, "_o_busy"}, 32'(o_busy), 32'd0);
        chk({nm, "_o_done"}, 32'(o_done), 32'd0);
        chk({nm, "_o_cfg_err"}, 32'(o_cfg_err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] pf;
        logic [8:0]  v;
        int          k;
        int          n;
        bit          rate;

        repeat (3) @(posedge sys_clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check_zero_outputs("post_reset");

        // K=3 rate 1/2, polys 7,5, bits 1011.
        rmode = 0;
        logq.delete();
        frame_bits = '{1, 0, 1, 1};
        run_frame(3, 0, mkpf(9'o7, 9'o5, 9'o0), 0);
        check_test1("t1");

        // Same frame under 1,0,0,1 backpressure.
        rmode = 1;
        logq.delete();
        run_frame(3, 0, mkpf(9'o7, 9'o5, 9'o0), 0);
        check_test1("t2");

        // K=9 rate 1/3 impulse: with a tail each lane replays its polynomial.
        rmode = 0;
        logq.delete();
        frame_bits = '{1};
        run_frame(9, 1, mkpf(9'o557, 9'o663, 9'o711), 0);
`ifdef ENDEC_ZERO_TAIL_EN
        for (int j = 0; j < 3; j++) begin
            v = '0;
            for (int t = 0; t < 9 && t < logq.size(); t++) v[t] = logq[t][j];
            chk("impulse_lane", 32'(v), 32'(j == 0 ? 9'o557 : (j == 1 ? 9'o663 : 9'o711)));
        end
`else
        chk("impulse_sym", 32'(logq.size() > 0 ? logq[0] : 4'h0), 32'h0f);
`endif

        // Rejected configurations.
        cfg_err_try(2, 0, mkpf(9'o7, 9'o5, 9'o0));
        cfg_err_try(3, 0, mkpf(9'o0, 9'o5, 9'o0));
        cfg_err_try(10, 0, mkpf(9'o7, 9'o5, 9'o0));
        cfg_err_try(3, 1, mkpf(9'o7, 9'o5, 9'o0));
        cfg_err_try(3, 0, mkpf(9'o10, 9'o5, 9'o0));

        // Abort after 2 of 4 bits, then rerun the first frame.
        frame_bits = '{1, 0, 1, 1};
        push_model(3, 0, mkpf(9'o7, 9'o5, 9'o0));
        start_cfg(3, 0, mkpf(9'o7, 9'o5, 9'o0));
        send_bit(1, 0);
        send_bit(0, 0);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        expq.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("abort_no_done", 32'(done_cnt), 32'(frames));
        logq.delete();
        run_frame(3, 0, mkpf(9'o7, 9'o5, 9'o0), 0);
        check_test1("t5");

        // Random frames against the model.
        for (int f = 0; f < 30; f++) begin
            k    = $urandom_range(3, 9);
            rate = 1'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) begin
                do v = 9'($urandom_range(0, 511));
                while ((v & 9'((1 << k) - 1)) == 0);
                pf[j*9 +: 9] = v;
            end
            n = $urandom_range(1, 16);
            frame_bits.delete();
            for (int b = 0; b < n; b++) frame_bits.push_back(1'($urandom_range(0, 1)));
            rmode = (f % 3 == 0) ? 0 : 2;
            run_frame(k, rate, pf, f % 4);
        end

        chk("cfg_err_total", 32'(cerr_cnt), 32'(cerr_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
